unit_dispatch_controller: RTL and testbench

UNIT_DISPATCH_CONTROLLER -- requirements
Module: unit_dispatch_controller

---
 rtl/unit_dispatch_controller_if.sv | 33 +++
 rtl/unit_dispatch_controller.sv | 138 +++++++++++++
 tb/tb_unit_dispatch_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/unit_dispatch_controller_if.sv
// Handshake bundle between the main sequencer, the execution units, the bus and the
// dispatch controller. The slave modport is the controller's view; master is the environment.
interface unit_dispatch_controller_if #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned UW        = $clog2(NUM_UNITS)
) ();
    logic                 start;
    logic [UW-1:0]        unitSelect;
    logic                 memRead;
    logic                 memWrite;
    logic [NUM_UNITS-1:0] unitStart;
    logic [NUM_UNITS-1:0] unitDone;
    logic                 memRequest;
    logic                 waitRequest;
    logic                 readValid;
    logic                 busy;
    logic                 enable;
    logic                 timeoutException;
    logic [1:0]           faultCode;
    logic                 clearFault;

    modport slave (
        input  start, unitSelect, memRead, memWrite, unitDone, waitRequest, readValid,
        input  clearFault,
        output unitStart, memRequest, busy, enable, timeoutException, faultCode
    );

    modport master (
        output start, unitSelect, memRead, memWrite, unitDone, waitRequest, readValid,
        output clearFault,
        input  unitStart, memRequest, busy, enable, timeoutException, faultCode
    );
endinterface

// File: rtl/unit_dispatch_controller.sv
// Dispatches one operation to a multi-cycle execution unit, optionally follows it with a
// bus read or write, and reports completion or a per-phase timeout fault. Moore outputs.
module unit_dispatch_controller #(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    unit_dispatch_controller_if.slave    io_bus
);
    localparam int unsigned UW = $clog2(NUM_UNITS);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StIssue, StUnitWait, StMemReq, StMemData, StComplete, StFault
    } state_e;

    state_e          r_state_q, w_state_d;
    logic [UW-1:0]   r_sel_q, w_sel_d;
    logic            r_rd_q, w_rd_d;
    logic            r_wr_q, w_wr_d;
    logic [1:0]      r_code_q, w_code_d;
    logic [CW-1:0]   r_cnt_q, w_cnt_d;

    logic [NUM_UNITS-1:0] w_onehot;
    logic                 w_done_sel;
    logic                 w_expire;
    logic                 w_entering;
    logic                 w_next_counts;

    assign w_onehot   = {{(NUM_UNITS-1){1'b0}}, 1'b1} << r_sel_q;
    // Only the selected unit's strobe matters; others are masked off.
    assign w_done_sel = |(io_bus.unitDone & w_onehot);
    assign w_expire   = (r_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // State, operation latches, fault code and timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= StIdle;
            r_sel_q   <= '0;
            r_rd_q    <= 1'b0;
            r_wr_q    <= 1'b0;
            r_code_q  <= 2'b00;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sel_q   <= w_sel_d;
            r_rd_q    <= w_rd_d;
            r_wr_q    <= w_wr_d;
            r_code_q  <= w_code_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // Next-state sequencing; an event in the final allowed cycle beats the timeout.
    always_comb begin
        w_state_d = r_state_q;
        w_sel_d   = r_sel_q;
        w_rd_d    = r_rd_q;
        w_wr_d    = r_wr_q;
        w_code_d  = r_code_q;
        unique case (r_state_q)
            StIdle: begin
                if (io_bus.start) begin
                    w_sel_d   = io_bus.unitSelect;
                    w_rd_d    = io_bus.memRead;
                    w_wr_d    = io_bus.memWrite;
                    w_state_d = StIssue;
                end
            end
            StIssue, StUnitWait: begin
                if (w_done_sel) begin
                    w_state_d = (r_rd_q || r_wr_q) ? StMemReq : StComplete;
                end else if (w_expire) begin
                    w_state_d = StFault;
                    w_code_d  = 2'b01;
                end else begin
                    w_state_d = StUnitWait;
                end
            end
            StMemReq: begin
                if (!io_bus.waitRequest) begin
                    // Read takes priority when both read and write were requested.
                    w_state_d = r_rd_q ? StMemData : StComplete;
                end else if (w_expire) begin
                    w_state_d = StFault;
                    w_code_d  = 2'b10;
                end
            end
            StMemData: begin
                if (io_bus.readValid) begin
                    w_state_d = StComplete;
                end else if (w_expire) begin
                    w_state_d = StFault;
                    w_code_d  = 2'b11;
                end
            end
            StComplete: begin
                w_state_d = StIdle;
            end
            StFault: begin
                if (io_bus.clearFault) begin
                    w_state_d = StIdle;
                    w_code_d  = 2'b00;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_code_d  = 2'b00;
            end
        endcase
    end

    // Counter restarts on entry to each timed phase and runs while a phase is pending.
    always_comb begin
        w_entering    = (w_state_d != r_state_q) &&
                        (w_state_d == StIssue || w_state_d == StMemReq ||
                         w_state_d == StMemData);
        w_next_counts = (w_state_d == StIssue || w_state_d == StUnitWait ||
                         w_state_d == StMemReq || w_state_d == StMemData);
        w_cnt_d       = '0;
        if (w_entering) begin
            w_cnt_d = '0;
        end else if (w_next_counts) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Outputs decoded purely from registered state and latches.
    always_comb begin
        io_bus.unitStart        = (r_state_q == StIssue) ? w_onehot : '0;
        io_bus.memRequest       = (r_state_q == StMemReq);
        io_bus.busy             = (r_state_q != StIdle);
        io_bus.enable           = (r_state_q == StComplete);
        io_bus.timeoutException = (r_state_q == StFault);
        io_bus.faultCode        = (r_state_q == StFault) ? r_code_q : 2'b00;
    end
endmodule

// File: tb/tb_unit_dispatch_controller.sv
// Randomised bench: each operation is described by its delays, expanded arithmetically into
// a per-cycle timeline of stimulus and expected Moore outputs, then replayed against the DUT.
module tb_unit_dispatch_controller;
    localparam int NU = 4;
    localparam int T  = 8;
    localparam int UW = 2;

    typedef struct {
        logic          start;
        logic [UW-1:0] sel;
        logic          rd;
        logic          wr;
        logic [NU-1:0] done;
        logic          wreq;
        logic          rv;
        logic          clr;
        logic [NU-1:0] e_ust;
        logic          e_mreq;
        logic          e_busy;
        logic          e_en;
        logic          e_tex;
        logic [1:0]    e_fc;
    } cyc_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   op_id  = 0;
    cyc_t q[$];

    always #5 clk = ~clk;

    unit_dispatch_controller_if #(.NUM_UNITS(NU)) bus ();

    unit_dispatch_controller #(
        .NUM_UNITS      (NU),
        .TIMEOUT_CYCLES (T)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input cyc_t c);
        chk({tag, ".unitStart"}, 32'(bus.unitStart), 32'(c.e_ust));
        chk({tag, ".memRequest"}, 32'(bus.memRequest), 32'(c.e_mreq));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(c.e_busy));
        chk({tag, ".enable"}, 32'(bus.enable), 32'(c.e_en));
        chk({tag, ".timeoutException"}, 32'(bus.timeoutException), 32'(c.e_tex));
        chk({tag, ".faultCode"}, 32'(bus.faultCode), 32'(c.e_fc));
    endtask

    function automatic cyc_t blank();
        cyc_t c;
        c.start = 1'b0; c.sel = '0; c.rd = 1'b0; c.wr = 1'b0; c.done = '0;
        c.wreq = 1'b0; c.rv = 1'b0; c.clr = 1'b0;
        c.e_ust = '0; c.e_mreq = 1'b0; c.e_busy = 1'b0; c.e_en = 1'b0;
        c.e_tex = 1'b0; c.e_fc = 2'b00;
        return c;
    endfunction

    // Busy cycle with random values on every input the controller must ignore there.
    function automatic cyc_t noise();
        cyc_t c = blank();
        c.start  = 1'($urandom);
        c.sel    = UW'($urandom);
        c.rd     = 1'($urandom);
        c.wr     = 1'($urandom);
        c.done   = NU'($urandom);
        c.wreq   = 1'($urandom);
        c.rv     = 1'($urandom);
        c.e_busy = 1'b1;
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        bus.start       = c.start;
        bus.unitSelect  = c.sel;
        bus.memRead     = c.rd;
        bus.memWrite    = c.wr;
        bus.unitDone    = c.done;
        bus.waitRequest = c.wreq;
        bus.readValid   = c.rv;
        bus.clearFault  = c.clr;
    endtask

    // d/w/v: cycles from phase entry until done/accept/readValid; >= T means never in time.
    task automatic build_op(input int sel, input bit rd, input bit wr,
                            input int d, input int w, input int v);
        cyc_t          c;
        logic [NU-1:0] oh;
        int            code;
        int            n;
        int            h;
        oh   = NU'(1) << sel;
        code = 0;
        c = blank(); c.start = 1'b1; c.sel = UW'(sel); c.rd = rd; c.wr = wr;
        q.push_back(c);
        n = (d < T) ? d + 1 : T;
        for (int k = 0; k < n; k++) begin
            c = noise();
            c.done  = (c.done & ~oh) | ((k == d) ? oh : '0);
            c.e_ust = (k == 0) ? oh : '0;
            q.push_back(c);
        end
        if (d >= T) code = 1;
        if (code == 0 && (rd || wr)) begin
            n = (w < T) ? w + 1 : T;
            for (int j = 0; j < n; j++) begin
                c = noise(); c.wreq = (j < w); c.e_mreq = 1'b1;
                q.push_back(c);
            end
            if (w >= T) code = 2;
        end
        if (code == 0 && rd) begin
            n = (v < T) ? v + 1 : T;
            for (int m = 0; m < n; m++) begin
                c = noise(); c.rv = (m == v);
                q.push_back(c);
            end
            if (v >= T) code = 3;
        end
        if (code == 0) begin
            c = noise(); c.e_en = 1'b1;
            q.push_back(c);
        end else begin
            h = $urandom_range(1, 3);
            for (int i = 0; i <= h; i++) begin
                c = noise(); c.e_tex = 1'b1; c.e_fc = 2'(code); c.clr = (i == h);
                q.push_back(c);
            end
        end
        q.push_back(blank());
    endtask

    task automatic run_q();
        foreach (q[i]) begin
            @(negedge clk);
            chk_all($sformatf("op%0d.c%0d", op_id, i), q[i]);
            drive(q[i]);
        end
        q.delete();
        op_id++;
    endtask

    task automatic op(input int sel, input bit rd, input bit wr,
                      input int d, input int w, input int v);
        build_op(sel, rd, wr, d, w, v);
        run_q();
    endtask

    cyc_t zero;
    cyc_t exp_c;

    initial begin
        zero = blank();
        drive(zero);
        reset = 1'b0;
        #1 chk_all("reset", zero);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed cases.
        op(2, 0, 0, 3, 0, 0);       // unit only, done 3 cycles after issue
        op(1, 1, 0, 1, 4, 2);       // read, 4 stall cycles, data 2 cycles after accept
        op(0, 0, 0, T, 0, 0);       // selected unit never done -> code 01
        op(0, 0, 1, 0, T, 0);       // bus never accepts -> code 10
        op(3, 1, 1, 2, 0, T - 1);   // read+write as read, data at last allowed cycle
        op(1, 1, 0, 0, 0, T);       // read data never arrives -> code 11
        op(2, 0, 1, T - 1, T - 1, 0); // events on the final allowed cycle of each phase

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            op($urandom_range(0, NU - 1), 1'($urandom), 1'($urandom),
               $urandom_range(0, T + 1), $urandom_range(0, T + 1), $urandom_range(0, T + 1));
        end

        // Asynchronous reset in MEM_DATA with start held high throughout.
        @(negedge clk);
        exp_c = zero;
        chk_all("rst.idle", exp_c);
        bus.start = 1'b1; bus.unitSelect = 2'd3; bus.memRead = 1'b1; bus.memWrite = 1'b0;
        @(negedge clk);
        exp_c = zero; exp_c.e_busy = 1'b1; exp_c.e_ust = 4'b1000;
        chk_all("rst.issue", exp_c);
        bus.unitDone = 4'b1000;
        @(negedge clk);
        exp_c = zero; exp_c.e_busy = 1'b1; exp_c.e_mreq = 1'b1;
        chk_all("rst.memreq", exp_c);
        bus.unitDone = '0; bus.waitRequest = 1'b0;
        @(negedge clk);
        exp_c = zero; exp_c.e_busy = 1'b1;
        chk_all("rst.memdata", exp_c);
        #2 reset = 1'b0;
        #1 chk_all("rst.async", zero);
        @(posedge clk);
        #1 chk_all("rst.held", zero);
        @(negedge clk);
        bus.unitSelect = 2'd2; bus.memRead = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_c = zero; exp_c.e_busy = 1'b1; exp_c.e_ust = 4'b0100;
        chk_all("rst.first_start", exp_c);
        @(negedge clk);
        bus.start = 1'b0; bus.unitDone = 4'b0100;
        @(negedge clk);
        exp_c = zero; exp_c.e_busy = 1'b1; exp_c.e_en = 1'b1;
        chk_all("rst.complete", exp_c);
        drive(zero);
        @(negedge clk);
        chk_all("rst.done", zero);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
